// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemReady;
    logic [15:0] imemRdata;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemRdata
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemRdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns pcF, drives the imem handshake and the IF/ID register,
// and absorbs stalls, flushes and redirects that land while a request is in flight.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallF,
    input  logic                 flushD,
    input  logic                 pcSrcE,
    input  logic [15:0]          pcTargetE,
    fetch_stage_if.master        imem,
    output logic [15:0]          inst,
    output logic [15:0]          PCPlus2,
    output logic [15:0]          PCD,
    output logic                 validD
);

    typedef enum logic [1:0] {StFetch, StDrain, StHold} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] redir_q, redir_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] pcplus2_q, pcplus2_d;
    logic [15:0] pcd_q, pcd_d;
    logic        valid_q, valid_d;
    logic [15:0] pc_inc;

    logic        want_load;
    logic        want_bubble;
    logic [15:0] load_inst;

    assign pc_inc = pc_q + 16'd2;

    // Request is masked during reset so an in-flight access is abandoned at once.
    assign imem.imemReq  = rst && (state_q != StHold);
    assign imem.imemAddr = pc_q;

    assign inst    = inst_q;
    assign PCPlus2 = pcplus2_q;
    assign PCD     = pcd_q;
    assign validD  = valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        hold_d      = hold_q;
        want_load   = 1'b0;
        want_bubble = 1'b0;
        load_inst   = imem.imemRdata;

        unique case (state_q)
            StFetch: begin
                if (pcSrcE) begin
                    want_bubble = 1'b1;
                    if (imem.imemReady) begin
                        pc_d = pcTargetE;
                    end else begin
                        redir_d = pcTargetE;
                        state_d = StDrain;
                    end
                end else if (imem.imemReady) begin
                    if (!stallF) begin
                        want_load = 1'b1;
                        pc_d      = pc_inc;
                    end else begin
                        hold_d  = imem.imemRdata;
                        state_d = StHold;
                    end
                end else begin
                    want_bubble = 1'b1;
                end
            end
            StDrain: begin
                want_bubble = 1'b1;
                if (pcSrcE) begin
                    redir_d = pcTargetE;
                end
                // Response to the stale address completes the handshake and is thrown away.
                if (imem.imemReady) begin
                    pc_d    = pcSrcE ? pcTargetE : redir_q;
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (pcSrcE) begin
                    want_bubble = 1'b1;
                    pc_d        = pcTargetE;
                    state_d     = StFetch;
                end else if (!stallF) begin
                    want_load = 1'b1;
                    load_inst = hold_q;
                    pc_d      = pc_inc;
                    state_d   = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        inst_d    = inst_q;
        pcplus2_d = pcplus2_q;
        pcd_d     = pcd_q;
        valid_d   = valid_q;
        if (flushD || (want_bubble && !stallF)) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (want_load && !stallF) begin
            inst_d    = load_inst;
            pcplus2_d = pc_inc;
            pcd_d     = pc_q;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            redir_q   <= 16'h0000;
            hold_q    <= 16'h0000;
            inst_q    <= NOP_INST;
            pcplus2_q <= 16'h0000;
            pcd_q     <= 16'h0000;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            hold_q    <= hold_d;
            inst_q    <= inst_d;
            pcplus2_q <= pcplus2_d;
            pcd_q     <= pcd_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a few hand-written reset sequences.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        flushD;
    logic        pcSrcE;
    logic [15:0] pcTargetE;
    logic [15:0] inst;
    logic [15:0] PCPlus2;
    logic [15:0] PCD;
    logic        validD;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INST (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stallF    (stallF),
        .flushD    (flushD),
        .pcSrcE    (pcSrcE),
        .pcTargetE (pcTargetE),
        .imem      (imem),
        .inst      (inst),
        .PCPlus2   (PCPlus2),
        .PCD       (PCD),
        .validD    (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] rdata;
        logic        ereq;
        logic [15:0] eaddr;
        logic [15:0] einst;
        logic [15:0] ep2;
        logic [15:0] epcd;
        logic        evalid;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   passed;

    function automatic vec_t mk(logic st, logic fl, logic ps, logic [15:0] tg, logic rd,
                                logic [15:0] da, logic rq, logic [15:0] ad, logic [15:0] ei,
                                logic [15:0] e2, logic [15:0] ep, logic ev);
        vec_t v;
        v.stall = st; v.flush = fl; v.pcsrc = ps; v.tgt = tg; v.rdy = rd; v.rdata = da;
        v.ereq = rq; v.eaddr = ad; v.einst = ei; v.ep2 = e2; v.epcd = ep; v.evalid = ev;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_ifid(string tag, logic [15:0] ei, logic [15:0] e2, logic [15:0] ep,
                            logic ev);
        chk({tag, " inst"}, inst, ei);
        chk({tag, " PCPlus2"}, PCPlus2, e2);
        chk({tag, " PCD"}, PCD, ep);
        chk({tag, " validD"}, {15'd0, validD}, {15'd0, ev});
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b0;
        stallF = 1'b0;
        flushD = 1'b0;
        pcSrcE = 1'b0;
        pcTargetE = 16'h0000;
        imem.imemReady = 1'b0;
        imem.imemRdata = 16'h0000;

        //          st fl ps tgt      rd rdata    req addr     inst     p2       pcd      v
        // zero-wait stream
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h6103, 1, 16'h0000, 16'h6103, 16'h0002, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0002, 16'h1234, 16'h0004, 16'h0002, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5678, 1, 16'h0004, 16'h5678, 16'h0006, 16'h0004, 1));
        // two wait states
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 16'h0000, 16'h0006, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 16'h0000, 16'h0006, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h0006, 16'hAAAA, 16'h0008, 16'h0006, 1));
        // stall on ready -> HOLD, release
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hBBBB, 1, 16'h0008, 16'hAAAA, 16'h0008, 16'h0006, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hDEAD, 0, 16'h0008, 16'hAAAA, 16'h0008, 16'h0006, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 16'hBBBB, 16'h000A, 16'h0008, 1));
        // redirect to 0x0040 while request to 0x000A waits
        vecs.push_back(mk(0, 1, 1, 16'h0040, 0, 16'h0000, 1, 16'h000A, 16'h0000, 16'h000A, 16'h0008, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h000A, 16'h0000, 16'h000A, 16'h0008, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hCCCC, 1, 16'h000A, 16'h0000, 16'h000A, 16'h0008, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hDDDD, 1, 16'h0040, 16'hDDDD, 16'h0042, 16'h0040, 1));
        // zero-wait redirect to 0xFFFE, then wrap
        vecs.push_back(mk(0, 1, 1, 16'hFFFE, 1, 16'hEEEE, 1, 16'h0042, 16'h0000, 16'h0042, 16'h0040, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'hFFFE, 16'h1111, 16'h0000, 16'hFFFE, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0000, 16'h2222, 16'h0002, 16'h0000, 1));
        // redirect out of HOLD, honoured under stall
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0002, 16'h2222, 16'h0002, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 1, 16'h0100, 0, 16'h0000, 0, 16'h0002, 16'h2222, 16'h0002, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0100, 16'h4444, 16'h0102, 16'h0100, 1));
        // DRAIN: newest target wins, stall during drain completion
        vecs.push_back(mk(0, 0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0102, 16'h0000, 16'h0102, 16'h0100, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0300, 0, 16'h0000, 1, 16'h0102, 16'h0000, 16'h0102, 16'h0100, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0102, 16'h0000, 16'h0102, 16'h0100, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0300, 16'h6666, 16'h0302, 16'h0300, 1));
        // DRAIN: redirect in the same cycle as ready
        vecs.push_back(mk(0, 0, 1, 16'h0400, 0, 16'h0000, 1, 16'h0302, 16'h0000, 16'h0302, 16'h0300, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0500, 1, 16'h9999, 1, 16'h0302, 16'h0000, 16'h0302, 16'h0300, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h7777, 1, 16'h0500, 16'h7777, 16'h0502, 16'h0500, 1));
        // flush with ready, no redirect: data dropped, pcF advances
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h8888, 1, 16'h0502, 16'h0000, 16'h0502, 16'h0500, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0504, 16'h0000, 16'h0502, 16'h0500, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset imemReq", {15'd0, imem.imemReq}, 16'h0000);
        chk("reset imemAddr", imem.imemAddr, 16'h0000);
        chk_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            stallF = vecs[i].stall;
            flushD = vecs[i].flush;
            pcSrcE = vecs[i].pcsrc;
            pcTargetE = vecs[i].tgt;
            imem.imemReady = vecs[i].rdy;
            imem.imemRdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d imemReq", i), {15'd0, imem.imemReq}, {15'd0, vecs[i].ereq});
            chk($sformatf("v%0d imemAddr", i), imem.imemAddr, vecs[i].eaddr);
            @(posedge clk);
            #1;
            chk_ifid($sformatf("v%0d", i), vecs[i].einst, vecs[i].ep2, vecs[i].epcd,
                     vecs[i].evalid);
        end

        // Reset asserted mid-DRAIN
        @(negedge clk);
        stallF = 1'b0;
        flushD = 1'b0;
        pcSrcE = 1'b1;
        pcTargetE = 16'h0600;
        imem.imemReady = 1'b0;
        @(posedge clk);
        #1;
        pcSrcE = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("midrst imemReq", {15'd0, imem.imemReq}, 16'h0000);
        chk("midrst imemAddr", imem.imemAddr, 16'h0000);
        chk_ifid("midrst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        imem.imemReady = 1'b1;
        imem.imemRdata = 16'h9ABC;
        #1;
        chk("postrst imemReq", {15'd0, imem.imemReq}, 16'h0001);
        chk("postrst imemAddr", imem.imemAddr, 16'h0000);
        @(posedge clk);
        #1;
        chk_ifid("postrst", 16'h9ABC, 16'h0002, 16'h0000, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
